divider: RTL and testbench

- Multi-cycle signed 32-bit integer divider for the datapath's HI/LO unit; the inverse operation of the shift-add multiplier that shares the HI/LO registers.
- Implements MIPS DIV semantics: LO = quotient (truncated toward zero), HI = remainder (sign of dividend).
- Restoring shift-subtract algorithm, one quotient bit per clock.
- Started by the control unit with DivCtrl; completion reported on DivOUT; divide-by-zero flagged on DivZero for the exception logic.

---
 rtl/divider_pkg.sv | 14 +
 rtl/divider_if.sv | 36 +++
 rtl/divider_step.sv | 24 ++
 rtl/divider.sv | 119 +++++++++++
 tb/tb_divider.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/divider_pkg.sv
// Shared constants and state encoding for the HI/LO restoring divider.
// Optional DIVU support is enabled by defining DIVIDER_UNSIGNED_EN.
package divider_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/divider_if.sv
// Control-unit <-> divider handshake and HI/LO result bundle.
// DivU is present only when DIVIDER_UNSIGNED_EN is defined.
interface divider_if
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic             DivCtrl;
  logic [WIDTH-1:0] dividendo;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic             DivOUT;
  logic             DivZero;
`ifdef DIVIDER_UNSIGNED_EN
  logic             DivU;
`endif

  modport master (
`ifdef DIVIDER_UNSIGNED_EN
    output DivU,
`endif
    output DivCtrl, dividendo, divisor,
    input  HI, LO, DivOUT, DivZero
  );

  modport slave (
`ifdef DIVIDER_UNSIGNED_EN
    input  DivU,
`endif
    input  DivCtrl, dividendo, divisor,
    output HI, LO, DivOUT, DivZero
  );

endinterface

// File: rtl/divider_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes.
// The shifted remainder keeps one extra bit so full-range unsigned divisors compare correctly.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH:0] w_sh;
  logic [WIDTH:0] w_dvs;
  logic           w_ge;

  assign w_sh  = {i_rem, i_q[WIDTH-1]};
  assign w_dvs = {1'b0, i_dvs};
  assign w_ge  = (w_sh >= w_dvs);

  assign o_rem = w_ge ? WIDTH'(w_sh - w_dvs) : w_sh[WIDTH-1:0];
  assign o_q   = {i_q[WIDTH-2:0], w_ge};

endmodule

// File: rtl/divider.sv
// Multi-cycle MIPS DIV unit: one quotient bit per clock, sign fix-up in a final cycle.
// Defining DIVIDER_UNSIGNED_EN adds DIVU (raw unsigned operands, no sign correction).
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic     clk,
  input  logic     reset_n,
  divider_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  function automatic logic [WIDTH-1:0] f_mag(input logic signed [WIDTH-1:0] v, input logic raw);
    if (!raw && (v < 0)) return -v;
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  state_t             r_state;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_dvs;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sign_q;
  logic               r_sign_r;
  logic               r_zero_pend;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_out;
  logic               r_zero;

  logic                      w_raw;
  logic signed [WIDTH-1:0]   w_dividend_s;
  logic signed [WIDTH-1:0]   w_divisor_s;
  logic [WIDTH-1:0]          w_rem_nx;
  logic [WIDTH-1:0]          w_q_nx;

`ifdef DIVIDER_UNSIGNED_EN
  assign w_raw = bus.DivU;
`else
  assign w_raw = 1'b0;
`endif

  assign w_dividend_s = bus.dividendo;
  assign w_divisor_s  = bus.divisor;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem (r_rem),
    .i_q   (r_q),
    .i_dvs (r_dvs),
    .o_rem (w_rem_nx),
    .o_q   (w_q_nx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_rem       <= '0;
      r_q         <= '0;
      r_dvs       <= '0;
      r_cnt       <= '0;
      r_sign_q    <= 1'b0;
      r_sign_r    <= 1'b0;
      r_zero_pend <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_out       <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      r_out  <= 1'b0;
      r_zero <= 1'b0;
      case (r_state)
        IDLE: begin
          // Divide-by-zero completes one edge after acceptance without leaving IDLE.
          r_out       <= r_zero_pend;
          r_zero      <= r_zero_pend;
          r_zero_pend <= 1'b0;
          if (bus.DivCtrl) begin
            if (bus.divisor == '0) begin
              r_zero_pend <= 1'b1;
            end else begin
              r_q      <= f_mag(w_dividend_s, w_raw);
              r_dvs    <= f_mag(w_divisor_s, w_raw);
              r_sign_q <= !w_raw && (bus.dividendo[WIDTH-1] ^ bus.divisor[WIDTH-1]);
              r_sign_r <= !w_raw && bus.dividendo[WIDTH-1];
              r_rem    <= '0;
              r_cnt    <= '0;
              r_state  <= RUN;
            end
          end
        end
        RUN: begin
          r_rem <= w_rem_nx;
          r_q   <= w_q_nx;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= FIX;
        end
        FIX: begin
          r_lo    <= f_neg(r_q, r_sign_q);
          r_hi    <= f_neg(r_rem, r_sign_r);
          r_out   <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.HI      = r_hi;
  assign bus.LO      = r_lo;
  assign bus.DivOUT  = r_out;
  assign bus.DivZero = r_zero;

endmodule

// File: tb/tb_divider.sv
// Directed table-driven bench for divider plus abort-by-reset and back-to-back sequences.
module tb_divider;

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  always #5 clk = ~clk;

  divider_if #(.WIDTH(32)) bif ();

  divider #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        z;
  } vec_t;

  localparam int NV = 11;
  vec_t tv [NV];

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] m_lo = '0;
  logic [31:0] m_hi = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Launch one divide at edge E, then wait for DivOUT, checking latency, hold and results.
  task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] elo, input logic [31:0] ehi, input logic ez);
    int n;
    logic done;
    logic held;
    @(negedge clk);
    bif.DivCtrl   = 1'b1;
    bif.dividendo = a;
    bif.divisor   = b;
    @(posedge clk);
    #1;
    bif.DivCtrl   = 1'b0;
    bif.dividendo = $urandom;
    bif.divisor   = $urandom;
    n = 0;
    done = 1'b0;
    held = 1'b1;
    while (!done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (bif.DivOUT) done = 1'b1;
      else if (bif.LO !== m_lo || bif.HI !== m_hi) held = 1'b0;
    end
    chk({name, " latency"}, 32'(n), ez ? 32'd1 : 32'd33);
    chk({name, " hold"}, {31'd0, held}, 32'd1);
    chk({name, " LO"}, bif.LO, elo);
    chk({name, " HI"}, bif.HI, ehi);
    chk({name, " DivZero"}, {31'd0, bif.DivZero}, {31'd0, ez});
    m_lo = elo;
    m_hi = ehi;
    @(posedge clk);
    #1;
    chk({name, " pulse end"}, {30'd0, bif.DivOUT, bif.DivZero}, 32'd0);
  endtask

  initial begin
    int n;
    logic saw;

    tv[0]  = '{32'd100,      32'd7,        32'd14,       32'd2,        1'b0};
    tv[1]  = '{32'd5,        32'd0,        32'd14,       32'd2,        1'b1};
    tv[2]  = '{32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
    tv[3]  = '{32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0};
    tv[4]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0};
    tv[5]  = '{32'd0,        32'd5,        32'd0,        32'd0,        1'b0};
    tv[6]  = '{32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0};
    tv[7]  = '{32'h7FFFFFFF, 32'h80000000, 32'd0,        32'h7FFFFFFF, 1'b0};
    tv[8]  = '{32'h80000000, 32'h80000000, 32'd1,        32'd0,        1'b0};
    tv[9]  = '{32'h80000000, 32'd2,        32'hC0000000, 32'd0,        1'b0};
    tv[10] = '{32'd12345,    32'd1,        32'd12345,    32'd0,        1'b0};

    bif.DivCtrl   = 1'b0;
    bif.dividendo = '0;
    bif.divisor   = '0;
`ifdef DIVIDER_UNSIGNED_EN
    bif.DivU      = 1'b0;
`endif

    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset LO", bif.LO, 32'd0);
    chk("reset HI", bif.HI, 32'd0);
    chk("reset flags", {30'd0, bif.DivOUT, bif.DivZero}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++)
      run_div($sformatf("vec%0d", i), tv[i].a, tv[i].b, tv[i].lo, tv[i].hi, tv[i].z);

    // Abort: 1000/3 started, ignored restart at E+5, reset at E+10.
    @(negedge clk);
    bif.DivCtrl   = 1'b1;
    bif.dividendo = 32'd1000;
    bif.divisor   = 32'd3;
    @(posedge clk);
    #1 bif.DivCtrl = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    bif.DivCtrl   = 1'b1;
    bif.dividendo = 32'd77;
    bif.divisor   = 32'd0;
    @(posedge clk);
    #1 bif.DivCtrl = 1'b0;
    saw = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (bif.DivOUT || bif.DivZero) saw = 1'b1;
    end
    #1 reset_n = 1'b0;
    #1;
    chk("abort LO", bif.LO, 32'd0);
    chk("abort HI", bif.HI, 32'd0);
    chk("abort flags", {30'd0, bif.DivOUT, bif.DivZero}, 32'd0);
    m_lo = '0;
    m_hi = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bif.DivOUT || bif.DivZero) saw = 1'b1;
    end
    chk("abort no done", {31'd0, saw}, 32'd0);
    run_div("post-reset 9/3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

    // Back-to-back: 20/4, then 50/5 accepted on the edge that ends its DivOUT cycle.
    @(negedge clk);
    bif.DivCtrl   = 1'b1;
    bif.dividendo = 32'd20;
    bif.divisor   = 32'd4;
    @(posedge clk);
    #1 bif.DivCtrl = 1'b0;
    n = 0;
    while (!bif.DivOUT && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("b2b first latency", 32'(n), 32'd33);
    chk("b2b first LO", bif.LO, 32'd5);
    bif.DivCtrl   = 1'b1;
    bif.dividendo = 32'd50;
    bif.divisor   = 32'd5;
    @(posedge clk);
    #1;
    bif.DivCtrl   = 1'b0;
    bif.dividendo = $urandom;
    bif.divisor   = $urandom;
    n = 1;
    while (!bif.DivOUT && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("b2b second spacing", 32'(n), 32'd34);
    chk("b2b second LO", bif.LO, 32'd10);
    chk("b2b second HI", bif.HI, 32'd0);
    chk("b2b second DivZero", {31'd0, bif.DivZero}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
